fetch_irq_seq: RTL

- Parametrised instruction-fetch sequencer with interrupt handling; successor to the single-interrupt fetch/decode front end.
- Sits between the instruction RAM read port and the decode/control logic and selects the instruction passed to decode.
- Adds NUM_IRQ prioritised, maskable, latched interrupt sources, nested pre-emption up to NEST_DEPTH levels with a saved-PC stack, and wake-from-halt.

---
 rtl/fetch_irq_pkg.sv | 24 ++
 rtl/irq_save_stack.sv | 51 +++++
 rtl/fetch_irq_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fetch_irq_pkg.sv
// Shared opcodes, FSM encoding and jump-builder for the interrupt-aware fetch sequencer.
package fetch_irq_pkg;

    // Opcodes are held at 64 bits and truncated by the user to INST_W (INST_W <= 64).
    localparam logic [63:0] OP_NOP  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] OP_HALT = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam logic [63:0] OP_RETI = 64'hFFFF_FFFF_FFFF_FFFD;
    localparam logic [5:0]  OP_UCB  = 6'b000110;

    typedef enum logic [1:0] {
        NORM = 2'd0,
        INT  = 2'd1,
        HALT = 2'd2
    } state_e;

    function automatic logic [63:0] build_jump(input logic [63:0] target,
                                               input int          pc_w,
                                               input int          inst_w);
        logic [63:0] pc_mask;
        pc_mask = (64'd1 << pc_w) - 64'd1;
        return ({58'd0, OP_UCB} << (inst_w - 6)) | (target & pc_mask);
    endfunction

endpackage

// File: rtl/irq_save_stack.sv
// LIFO of {pc, id} return frames for nested interrupt service.
module irq_save_stack #(
    parameter int PC_W  = 10,
    parameter int ID_W  = 2,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [PC_W+ID_W-1:0]          din,
    output logic [PC_W+ID_W-1:0]          dout,
    output logic [$clog2(DEPTH+1)-1:0]    level
);

    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [PC_W+ID_W-1:0] mem_q [DEPTH];
    logic [LVL_W-1:0]     level_q;

    // NOTE: the frame storage is reset as well, so a stale frame can never leak out after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && level_q < LVL_W'(DEPTH)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (level_q == LVL_W'(i)) begin
                    mem_q[i] <= din;
                end
            end
            level_q <= level_q + LVL_W'(1);
        end else if (pop && level_q != '0) begin
            level_q <= level_q - LVL_W'(1);
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level_q == LVL_W'(i + 1)) begin
                dout = mem_q[i];
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/fetch_irq_seq.sv
// Instruction-fetch sequencer: selects the instruction issued to decode and inserts
// jumps for prioritised, maskable, nestable interrupts, RETI and wake-from-halt.
module fetch_irq_seq
    import fetch_irq_pkg::*;
#(
    parameter int PC_W       = 10,
    parameter int INST_W     = 32,
    parameter int NUM_IRQ    = 4,
    parameter int NEST_DEPTH = 2,
    parameter int HALT_WAKE  = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_IRQ-1:0]                          irq_req,
    input  logic [NUM_IRQ*PC_W-1:0]                     irq_vec,
    input  logic [NUM_IRQ-1:0]                          irq_mask,
    input  logic [PC_W-1:0]                             pc_from_ex,
    input  logic [INST_W-1:0]                           inst_from_iram,
    output logic [INST_W-1:0]                           current_inst,
    output logic [NUM_IRQ-1:0]                          irq_ack,
    output logic [((NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1)-1:0] active_id,
    output logic [$clog2(NEST_DEPTH+1)-1:0]             nest_level,
    output logic                                        available_for_int,
    output logic                                        halted
);

    localparam int ID_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int LVL_W = $clog2(NEST_DEPTH + 1);

    localparam logic [INST_W-1:0] NOP_I  = INST_W'(OP_NOP);
    localparam logic [INST_W-1:0] HALT_I = INST_W'(OP_HALT);
    localparam logic [INST_W-1:0] RETI_I = INST_W'(OP_RETI);

    state_e               state_q, state_d;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   ack_q, ack_d;
    logic                 settle_q, settle_d;
    logic [PC_W-1:0]      halt_pc_q, halt_pc_d;
    logic [ID_W-1:0]      active_q, active_d;

    logic [ID_W-1:0]      cand_id;
    logic                 cand_valid;
    logic [PC_W-1:0]      vec_sel, push_pc, pop_pc;
    logic [ID_W-1:0]      pop_id;
    logic [PC_W+ID_W-1:0] stack_dout;
    logic                 take, reti, is_halt, is_reti;
    logic                 depth_ok, prio_ok, norm_avail, wake_avail;

    function automatic logic [INST_W-1:0] jump_to(input logic [PC_W-1:0] t);
        return INST_W'(build_jump(64'(t), PC_W, INST_W));
    endfunction

    // Lowest index wins, so scan downwards and let the last hit stand.
    always_comb begin
        cand_valid = 1'b0;
        cand_id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_q[i] && !irq_mask[i]) begin
                cand_valid = 1'b1;
                cand_id    = ID_W'(i);
            end
        end
    end

    assign vec_sel = irq_vec[cand_id*PC_W +: PC_W];
    assign pop_pc  = stack_dout[ID_W +: PC_W];
    assign pop_id  = stack_dout[ID_W-1:0];
    assign is_halt = (inst_from_iram == HALT_I);
    assign is_reti = (inst_from_iram == RETI_I);

    assign depth_ok   = (nest_level < LVL_W'(NEST_DEPTH));
    assign prio_ok    = (state_q == NORM) || (cand_id < active_q);
    assign norm_avail = !settle_q && !is_halt && !is_reti && depth_ok && prio_ok;
    assign wake_avail = (HALT_WAKE != 0) && !settle_q && depth_ok;
    assign available_for_int = (state_q == HALT) ? wake_avail : norm_avail;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        current_inst = inst_from_iram;
        state_d      = state_q;
        halt_pc_d    = halt_pc_q;
        push_pc      = pc_from_ex;
        take         = 1'b0;
        reti         = 1'b0;
        unique case (state_q)
            NORM, INT: begin
                if (is_halt) begin
                    current_inst = NOP_I;
                    state_d      = HALT;
                    halt_pc_d    = pc_from_ex + PC_W'(1);
                end else if (is_reti) begin
                    current_inst = NOP_I;
                    if (state_q == INT) begin
                        reti         = 1'b1;
                        current_inst = jump_to(pop_pc);
                        state_d      = (nest_level == LVL_W'(1)) ? NORM : INT;
                    end
                end else if (cand_valid && norm_avail) begin
                    take         = 1'b1;
                    current_inst = jump_to(vec_sel);
                    state_d      = INT;
                end
            end
            HALT: begin
                current_inst = NOP_I;
                if (cand_valid && wake_avail) begin
                    take         = 1'b1;
                    push_pc      = halt_pc_q;
                    current_inst = jump_to(vec_sel);
                    state_d      = INT;
                end
            end
            default: state_d = NORM;
        endcase
    end

    // A fresh request on the ack edge re-arms the pending bit.
    assign ack_d     = take ? (NUM_IRQ'(1) << cand_id) : '0;
    assign pending_d = (pending_q & ~ack_d) | irq_req;
    assign settle_d  = take | reti;
    assign active_d  = take ? cand_id : (reti ? pop_id : active_q);

    // NOTE: state registers use non-blocking assignment so all of them update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= NORM;
            pending_q <= '0;
            ack_q     <= '0;
            settle_q  <= 1'b0;
            halt_pc_q <= '0;
            active_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            settle_q  <= settle_d;
            halt_pc_q <= halt_pc_d;
            active_q  <= active_d;
        end
    end

    irq_save_stack #(
        .PC_W  (PC_W),
        .ID_W  (ID_W),
        .DEPTH (NEST_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (take),
        .pop   (reti),
        .din   ({push_pc, active_q}),
        .dout  (stack_dout),
        .level (nest_level)
    );

    assign irq_ack   = ack_q;
    assign active_id = active_q;
    assign halted    = (state_q == HALT);

endmodule
